// File: rtl/mult_ctrl_pkg.sv
// Shared constants and types for the shift-add multiplier control unit.
package mult_ctrl_pkg;

   localparam int unsigned ITERS   = 4;
   localparam int unsigned CNT_W   = $clog2(ITERS);
   localparam int unsigned STATE_W = 3;

   // Legal state codes; 5-7 are unused and recover to IDLE.
   typedef enum logic [STATE_W-1:0] {
      IDLE  = 3'd0,
      INIT  = 3'd1,
      ADD   = 3'd2,
      SHIFT = 3'd3,
      DONE  = 3'd4
   } state_t;

   // Datapath control bundle driven by the decoder.
   typedef struct packed {
      logic s0;
      logic s1;
      logic s2;
      logic sig_rst;
      logic ld1;
      logic ld2;
   } ctrl_t;

endpackage

// File: rtl/mult_ctrl_decode.sv
// Moore output decoder: maps the current state code to datapath controls.
module mult_ctrl_decode
   import mult_ctrl_pkg::*;
(
   input  logic [STATE_W-1:0] ps,
   output logic               s0,
   output logic               s1,
   output logic               s2,
   output logic               sig_rst,
   output logic               ld1,
   output logic               ld2
);

   ctrl_t ctrl;

   // Decode state to controls; unlisted and illegal codes drive all zeros.
   always_comb begin
      ctrl = '0;
      case (ps)
         INIT: begin
            ctrl.sig_rst = 1'b1;
            ctrl.ld1     = 1'b1;
         end
         ADD: begin
            ctrl.s1  = 1'b1;
            ctrl.ld2 = 1'b1;
         end
         SHIFT: begin
            ctrl.s2  = 1'b1;
            ctrl.ld1 = 1'b1;
         end
         DONE: begin
            ctrl.s0 = 1'b1;
         end
         default: ctrl = '0;
      endcase
   end

   assign s0      = ctrl.s0;
   assign s1      = ctrl.s1;
   assign s2      = ctrl.s2;
   assign sig_rst = ctrl.sig_rst;
   assign ld1     = ctrl.ld1;
   assign ld2     = ctrl.ld2;

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Control FSM for the 4x4 shift-add multiplier: state register, iteration
// counter and output decoder.
module mult_ctrl_fsm
   import mult_ctrl_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic               s0,
   output logic               s1,
   output logic               s2,
   output logic               sig_rst,
   output logic               ld1,
   output logic               ld2,
   output logic [STATE_W-1:0] ps
);

   logic [STATE_W-1:0] state;
   logic [CNT_W-1:0]   cnt;

   // State and iteration counter; start is only looked at in IDLE and DONE.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) state <= INIT;
            end
            INIT: begin
               state <= ADD;
               cnt   <= '0;
            end
            ADD: begin
               state <= SHIFT;
            end
            SHIFT: begin
               if (cnt == CNT_W'(ITERS - 1)) begin
                  state <= DONE;
               end else begin
                  state <= ADD;
                  cnt   <= cnt + CNT_W'(1);
               end
            end
            DONE: begin
               if (!start) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign ps = state;

   mult_ctrl_decode u_decode (
      .ps      (state),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .sig_rst (sig_rst),
      .ld1     (ld1),
      .ld2     (ld2)
   );

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Self-checking bench for mult_ctrl_fsm: vector table with expected-state
// scoreboard, plus decoder sweep and illegal-state recovery.
module tb_mult_ctrl_fsm;
   import mult_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0;
   logic       s0, s1, s2, sig_rst, ld1, ld2;
   logic [2:0] ps;

   logic       d_s0, d_s1, d_s2, d_sig_rst, d_ld1, d_ld2;
   logic [2:0] dec_ps = 3'd0;

   mult_ctrl_fsm dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .s0      (s0),
      .s1      (s1),
      .s2      (s2),
      .sig_rst (sig_rst),
      .ld1     (ld1),
      .ld2     (ld2),
      .ps      (ps)
   );

   mult_ctrl_decode u_dec (
      .ps      (dec_ps),
      .s0      (d_s0),
      .s1      (d_s1),
      .s2      (d_s2),
      .sig_rst (d_sig_rst),
      .ld1     (d_ld1),
      .ld2     (d_ld2)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       start;
      logic [2:0] ps;
      string      tag;
   } vec_t;

   vec_t       vecs[$];
   logic [8:0] exp_q[$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         excl_bad = 0;

   // Expected {s0,s1,s2,sig_rst,ld1,ld2} for a state code.
   function automatic logic [5:0] spec_out(input logic [2:0] p);
      case (p)
         3'd1:    return 6'b000110;
         3'd2:    return 6'b010001;
         3'd3:    return 6'b001010;
         3'd4:    return 6'b100000;
         default: return 6'b000000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got ps=%0d outs=%b, expected ps=%0d outs=%b",
                  name, act[8:6], act[5:0], exp[8:6], exp[5:0]);
      end
   endtask

   task automatic add(input logic r, input logic s, input logic [2:0] p, input string t);
      vec_t v;
      v.rst = r; v.start = s; v.ps = p; v.tag = t;
      vecs.push_back(v);
   endtask

   // Full-run loop states seen after the INIT edge: 4x (ADD,SHIFT) then DONE.
   task automatic add_loop(input string t, input bit toggle);
      for (int i = 0; i < 8; i++)
         add(1'b1, toggle ? 1'(i % 2) : 1'b0, (i % 2 == 0) ? 3'd2 : 3'd3, t);
      add(1'b1, toggle ? 1'b0 : 1'b0, 3'd4, t);
   endtask

   initial begin
      // Reset held with start high, then released with start low.
      for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 3'd0, "reset");
      add(1'b1, 1'b0, 3'd0, "release");
      add(1'b1, 1'b0, 3'd0, "release");

      // Full run from a single start pulse.
      add(1'b1, 1'b1, 3'd1, "full");
      add_loop("full", 1'b0);
      add(1'b1, 1'b0, 3'd0, "full");

      // Held start: completes, parks in DONE, no second INIT.
      add(1'b1, 1'b1, 3'd1, "held");
      for (int i = 0; i < 8; i++) add(1'b1, 1'b1, (i % 2 == 0) ? 3'd2 : 3'd3, "held");
      for (int i = 0; i < 4; i++) add(1'b1, 1'b1, 3'd4, "held");
      add(1'b1, 1'b0, 3'd0, "held");
      add(1'b1, 1'b0, 3'd0, "held");

      // Reset during second-iteration SHIFT, then a clean full run.
      add(1'b1, 1'b1, 3'd1, "midrst");
      add(1'b1, 1'b0, 3'd2, "midrst");
      add(1'b1, 1'b0, 3'd3, "midrst");
      add(1'b1, 1'b0, 3'd2, "midrst");
      add(1'b1, 1'b0, 3'd3, "midrst");
      add(1'b0, 1'b1, 3'd0, "midrst");
      add(1'b1, 1'b1, 3'd1, "rerun");
      add_loop("rerun", 1'b0);
      add(1'b1, 1'b0, 3'd0, "rerun");

      // start toggling during the loop changes nothing.
      add(1'b1, 1'b1, 3'd1, "toggle");
      add_loop("toggle", 1'b1);
      add(1'b1, 1'b0, 3'd0, "toggle");

      foreach (vecs[i]) begin
         logic [8:0] e;
         @(negedge clk);
         rst   = vecs[i].rst;
         start = vecs[i].start;
         exp_q.push_back({vecs[i].ps, spec_out(vecs[i].ps)});
         @(posedge clk);
         #1;
         if (exp_q.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard: empty queue at vector %0d", i);
         end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s[%0d]", vecs[i].tag, i), {ps, s0, s1, s2, sig_rst, ld1, ld2}, e);
         end
         if (ld1 && ld2) excl_bad++;
      end

      n_cmp++;
      if (excl_bad != 0) begin
         n_bad++;
         $display("FAIL ld1_ld2_exclusive: got %0d overlapping cycles, expected 0", excl_bad);
      end

      // Decoder sweep over every code, including illegal 5-7.
      for (int p = 0; p < 8; p++) begin
         dec_ps = 3'(p);
         #1;
         chk($sformatf("decode[%0d]", p),
             {3'd0, d_s0, d_s1, d_s2, d_sig_rst, d_ld1, d_ld2},
             {3'd0, spec_out(3'(p))});
      end

      // Illegal state in the live FSM: outputs zero, recovers to IDLE.
      @(negedge clk);
      rst   = 1'b1;
      start = 1'b0;
      force dut.state = 3'd6;
      #1;
      chk("illegal_outs", {ps, s0, s1, s2, sig_rst, ld1, ld2}, {3'd6, 6'b000000});
      release dut.state;
      @(posedge clk);
      #1;
      chk("illegal_recover", {ps, s0, s1, s2, sig_rst, ld1, ld2}, {3'd0, 6'b000000});

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/mult_ctrl_fsm.md
Name: mult_ctrl_fsm

Overview:
- Control unit for the 4x4 shift-add multiplier.
- Contains a 3-bit Moore state machine (state register, next-state logic, 2-bit iteration counter) and a combinational output decoder.
- Decoder drives datapath mux selects s0/s1/s2, register clear sig_rst and load enables ld1/ld2.
- Sits between the top-level start input and the multiplier datapath.

Parameters:
- ITERS, 4, number of add/shift iterations (one per multiplier bit); counter width fixed at 2 bits for default.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  reset, synchronous, active-low (rst==0 at a rising clk edge resets)
- start  input  1  begin a multiplication; level-sensitive, sampled only in IDLE and DONE
- s0  output  1  result/output select; high in DONE
- s1  output  1  adder-input select; high in ADD
- s2  output  1  shift select; high in SHIFT
- sig_rst  output  1  synchronous clear of product register; high in INIT
- ld1  output  1  operand/shift register load enable; high in INIT and SHIFT
- ld2  output  1  product accumulator load enable; high in ADD
- ps  output  3  current state code (debug/trace)

Behaviour:
- State encodings: IDLE=0, INIT=1, ADD=2, SHIFT=3, DONE=4. Codes 5-7 are illegal.
- Reset: rst==0 at posedge forces ps=IDLE and cnt=0.
  - Reset overrides every other input.
  - Reset is honoured in any state; an in-progress multiplication is aborted.
- Transitions (evaluated each posedge when rst==1):
  - IDLE: start==1 -> INIT, else stay.
  - INIT -> ADD unconditionally; cnt <= 0.
  - ADD -> SHIFT unconditionally.
  - SHIFT: cnt==ITERS-1 -> DONE, else -> ADD with cnt <= cnt+1.
  - DONE: start==0 -> IDLE; start==1 -> stay in DONE. A held start never retriggers a second run.
  - Illegal codes 5-7 -> IDLE on next edge; all outputs 0 while in them.
- Outputs are purely combinational from ps (Moore); no glitch-free registering is required.
  - IDLE: all 0
  - INIT: sig_rst=1, ld1=1
  - ADD: s1=1, ld2=1
  - SHIFT: s2=1, ld1=1
  - DONE: s0=1
  - Every output not listed for a state is 0.
- Latency: start sampled high in IDLE at edge k gives:
  - INIT during cycle k+1
  - ADD/SHIFT alternating cycles k+2..k+9 (4 ADD, 4 SHIFT)
  - DONE from cycle k+10
  - Total 10 cycles from start to DONE.
- Exactly one of {ADD, SHIFT} per cycle during the loop; ld2 and ld1 are never high simultaneously.
- start changes during INIT/ADD/SHIFT are ignored.
- cnt is 2 bits for ITERS=4 and wraps only via the INIT reload; it never exceeds ITERS-1 in legal operation.

Decomposition:
- Shared package mult_ctrl_pkg holds:
  - the 3-bit state type/localparams (IDLE, INIT, ADD, SHIFT, DONE)
  - the ITERS constant
- One sub-module: mult_ctrl_decode, a purely combinational ps -> {s0, s1, s2, sig_rst, ld1, ld2} map.
- State register and counter stay in mult_ctrl_fsm.

Test Plan:
- Reset: hold rst=0 for 3 edges with start=1 -> ps=0, all six outputs 0 throughout. Release rst=1 with start=0 -> ps stays 0.
- Full run: rst=1, pulse start=1 then 0 -> ps sequence 0,1,2,3,2,3,2,3,2,3,4,0.
  - sig_rst=ld1=1 only in cycle 1.
  - ld2 high in exactly 4 cycles; s2 high in exactly 4 cycles.
  - s0=1 for exactly 1 cycle.
- Held start: start=1 continuously -> run completes and ps stays 4 (s0=1) until start=0, then ps=0. No second INIT occurs.
- Mid-run reset: assert rst=0 while ps=3 on second iteration -> next edge ps=0, outputs 0. A new start then yields a full 4-iteration run with cnt restarted.
- Start ignored mid-run: toggle start 1/0 every cycle during ADD/SHIFT -> sequence identical to the full-run case.
- Illegal state: force ps=6 -> all outputs 0, next edge ps=0.
